// File: rtl/pulse_train_gen_if.sv
// Command channel for pulse_train_gen: valid/ready handshake plus the high/low/count fields.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REP_W = 8
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [CNT_W-1:0] high_len_i;
  logic [CNT_W-1:0] low_len_i;
  logic [REP_W-1:0] count_i;

  modport master (
    output cmd_valid_i,
    output high_len_i,
    output low_len_i,
    output count_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  high_len_i,
    input  low_len_i,
    input  count_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Command-driven pulse train generator: emits count_i high pulses of the requested high/low lengths on wave_o.
// Optional macro PULSE_TRAIN_EDGE_FLAGS_EN adds registered rise_o/fall_o edge flags aligned with wave_o.
module pulse_train_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  pulse_train_gen_if.slave    cmd,
  input  logic                abort_i,
  output logic                wave_o,
  output logic                busy_o,
  output logic                done_o
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
  ,
  output logic                rise_o,
  output logic                fall_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [REP_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] high_len_q;
  logic [CNT_W-1:0] low_len_q;
  logic             accept;

  // A zero length behaves as one cycle, so the counter reload is max(len,1)-1.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign cmd.cmd_ready_o = (state == IDLE);
  assign accept          = cmd.cmd_valid_i && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      pulse_cnt  <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      wave_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
      rise_o <= 1'b0;
      fall_o <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // Abort is meaningless here; a coincident command is still taken.
          if (accept) begin
            if (cmd.count_i != '0) begin
              state      <= HIGH;
              wave_o     <= 1'b1;
              busy_o     <= 1'b1;
              high_len_q <= cmd.high_len_i;
              low_len_q  <= cmd.low_len_i;
              phase_cnt  <= phase_load(cmd.high_len_i);
              pulse_cnt  <= cmd.count_i;
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
              rise_o     <= 1'b1;
`endif
            end else begin
              done_o <= 1'b1;
            end
          end
        end

        HIGH: begin
          if (abort_i) begin
            state  <= IDLE;
            wave_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
            fall_o <= 1'b1;
`endif
          end else if (phase_cnt == '0) begin
            state     <= LOW;
            wave_o    <= 1'b0;
            phase_cnt <= phase_load(low_len_q);
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
            fall_o    <= 1'b1;
`endif
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end

        LOW: begin
          if (abort_i) begin
            state  <= IDLE;
            wave_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (phase_cnt == '0) begin
            pulse_cnt <= pulse_cnt - REP_W'(1);
            // Last pulse finishes only after its full low phase.
            if (pulse_cnt != REP_W'(1)) begin
              state     <= HIGH;
              wave_o    <= 1'b1;
              phase_cnt <= phase_load(high_len_q);
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
              rise_o    <= 1'b1;
`endif
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          wave_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed steps plus random commands checked against a waveform-queue model.
module tb_pulse_train_gen;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned REP_W = 8;

  logic clk;
  logic reset;
  logic abort_i;
  logic wave_o;
  logic busy_o;
  logic done_o;
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
  logic rise_o;
  logic fall_o;
`endif

  pulse_train_gen_if #(.CNT_W(CNT_W), .REP_W(REP_W)) cmd_if ();

  pulse_train_gen #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .cmd     (cmd_if.slave),
    .abort_i (abort_i),
    .wave_o  (wave_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
    ,
    .rise_o  (rise_o),
    .fall_o  (fall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: expected {wave,busy,done} for the current cycle and the queued future cycles.
  logic       cur_w = 1'b0;
  logic       cur_b = 1'b0;
  logic       cur_d = 1'b0;
  logic [2:0] sched[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic prev_w);
    chk("wave", wave_o, cur_w);
    chk("busy", busy_o, cur_b);
    chk("done", done_o, cur_d);
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
    chk("rise", rise_o, cur_w && !prev_w);
    chk("fall", fall_o, !cur_w && prev_w);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, clock, and compare.
  task automatic step(input logic v, input int h, input int l, input int n, input logic ab);
    logic [2:0] nxt;
    logic       prev_w;
    int         hh;
    int         ll;
    cmd_if.cmd_valid_i = v;
    cmd_if.high_len_i  = CNT_W'(h);
    cmd_if.low_len_i   = CNT_W'(l);
    cmd_if.count_i     = REP_W'(n);
    abort_i            = ab;
    chk("ready", cmd_if.cmd_ready_o, !cur_b);

    if (cur_b && ab) begin
      sched.delete();
      nxt = 3'b001;
    end else if (!cur_b && v) begin
      if (n != 0) begin
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        for (int p = 0; p < n; p++) begin
          for (int i = 0; i < hh; i++) sched.push_back(3'b110);
          for (int i = 0; i < ll; i++) sched.push_back(3'b010);
        end
        sched.push_back(3'b001);
        nxt = sched.pop_front();
      end else begin
        nxt = 3'b001;
      end
    end else if (sched.size() > 0) begin
      nxt = sched.pop_front();
    end else begin
      nxt = 3'b000;
    end

    prev_w = cur_w;
    {cur_w, cur_b, cur_d} = nxt;
    @(posedge clk);
    #1;
    check_outputs(prev_w);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    reset              = 1'b0;
    abort_i            = 1'b0;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.high_len_i  = '0;
    cmd_if.low_len_i   = '0;
    cmd_if.count_i     = '0;

    // Reset state while reset is held
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0);
    chk("ready_in_reset", cmd_if.cmd_ready_o, 1'b1);
    #2 reset = 1'b0;

    // Idle after reset
    idle(5);

    // H=3 L=2 N=2
    step(1'b1, 3, 2, 2, 1'b0);
    idle(11);

    // Zero lengths act as one cycle, then an empty command
    step(1'b1, 0, 0, 3, 1'b0);
    idle(7);
    step(1'b1, 5, 5, 0, 1'b0);
    idle(3);

    // Abort in the LOW phase of the first pulse, then immediate re-accept
    step(1'b1, 4, 4, 5, 1'b0);
    idle(5);
    step(1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 2, 1, 1, 1'b0);
    idle(5);

    // Valid held high continuously
    for (int i = 0; i < 12; i++) step(1'b1, 1, 1, 1, 1'b0);
    idle(3);

    // Abort coincident with a command in IDLE is ignored
    step(1'b1, 2, 2, 1, 1'b1);
    idle(5);

    // Asynchronous reset mid-HIGH drops the command without done
    step(1'b1, 10, 10, 2, 1'b0);
    idle(3);
    #2 reset = 1'b1;
    #1;
    sched.delete();
    cur_w = 1'b0;
    cur_b = 1'b0;
    cur_d = 1'b0;
    check_outputs(1'b0);
    chk("ready_mid_reset", cmd_if.cmd_ready_o, 1'b1);
    #2 reset = 1'b0;
    idle(3);

    // Maximum lengths and maximum pulse count
    step(1'b1, 255, 255, 1, 1'b0);
    idle(512);
    step(1'b1, 0, 0, 255, 1'b0);
    idle(512);

    // Randomized commands, fields and aborts
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) != 0, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
